// File: rtl/boss_bullet_pool.sv
// Multi-slot boss bullet engine: spawns bullets on a frame cadence with a rotating
// fire pattern, then erases, moves, bounds-checks and redraws each live slot.
module boss_bullet_pool #(
  parameter int         NUM_BULLETS  = 8,
  parameter int         FIRE_PERIOD  = 4,
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter int         X_OFFSET     = 4,
  parameter int         Y_SPLIT      = 90,
  parameter logic [2:0] BULLET_COLOR = 3'b101
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               start,
  input  logic [7:0]                         boss_x,
  input  logic [6:0]                         boss_y,
  output logic [7:0]                         x,
  output logic [6:0]                         y,
  output logic [2:0]                         color,
  output logic                               wren,
  output logic                               done,
  output logic [$clog2(NUM_BULLETS+1)-1:0]   active_count
);

  localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int CNT_W = $clog2(NUM_BULLETS + 1);
  localparam int FC_W  = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BULLETS - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FIRE_PERIOD - 1);
  localparam logic [8:0]       X_LIM    = 9'(SCREEN_W);
  localparam logic [7:0]       Y_LIM    = 8'(SCREEN_H);
  localparam logic [7:0]       X_OFF8   = 8'(X_OFFSET);
  localparam logic [6:0]       Y_SPLIT7 = 7'(Y_SPLIT);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_SCAN, S_ERASE, S_MOVE, S_DRAW, S_NEXT, S_DONE
  } state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [FC_W-1:0]         r_fc;
  logic [1:0]              r_pat;
  logic [NUM_BULLETS-1:0]  r_active;
  logic [NUM_BULLETS-1:0]  r_fresh;
  logic [NUM_BULLETS-1:0]  r_dy_up;
  logic [7:0]              r_px [NUM_BULLETS];
  logic [6:0]              r_py [NUM_BULLETS];
  logic [1:0]              r_dx [NUM_BULLETS];  // two's complement: 00=0, 11=-1, 01=+1
  logic [7:0]              r_x;
  logic [6:0]              r_y;
  logic [2:0]              r_color;
  logic                    r_wren;
  logic                    r_done;
  logic [CNT_W-1:0]        r_active_count;

  logic                    w_free_found;
  logic [IDX_W-1:0]        w_free_idx;
  logic [CNT_W-1:0]        w_pop;
  logic [1:0]              w_pat_dx;
  logic [7:0]              w_nx;
  logic [6:0]              w_ny;
  logic                    w_oob;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_pop        = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      w_pop = w_pop + CNT_W'(r_active[i]);
    end
  end

  assign w_pat_dx = (r_pat == 2'd0) ? 2'b00 : (r_pat == 2'd1) ? 2'b11 : 2'b01;
  assign w_nx     = r_px[r_idx] + {{6{r_dx[r_idx][1]}}, r_dx[r_idx]};
  assign w_ny     = r_py[r_idx] + (r_dy_up[r_idx] ? 7'h7f : 7'h01);
  // Wrapped underflow lands at 255/127, which this same check rejects.
  assign w_oob    = ({1'b0, w_nx} >= X_LIM) || ({1'b0, w_ny} >= Y_LIM);

  // NOTE: sequential state is written with <= only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_fc     <= '0;
      r_pat    <= '0;
      r_active <= '0;
      r_fresh  <= '0;
      r_dy_up  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_color  <= '0;
      r_wren   <= 1'b0;
      r_done   <= 1'b0;
      // NOTE: the slot arrays are a handful of flops, so they take the reset as well.
      for (int i = 0; i < NUM_BULLETS; i++) begin
        r_px[i] <= '0;
        r_py[i] <= '0;
        r_dx[i] <= '0;
      end
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_idx   <= '0;
            r_state <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          if (r_fc == FC_LAST) begin
            r_fc <= '0;
            if (w_free_found) begin
              r_active[w_free_idx] <= 1'b1;
              r_fresh[w_free_idx]  <= 1'b1;
              r_px[w_free_idx]     <= boss_x + X_OFF8;
              r_py[w_free_idx]     <= boss_y;
              r_dx[w_free_idx]     <= w_pat_dx;
              r_dy_up[w_free_idx]  <= (boss_y > Y_SPLIT7);
              r_pat                <= (r_pat == 2'd2) ? 2'd0 : r_pat + 2'd1;
            end
          end else begin
            r_fc <= r_fc + FC_W'(1);
          end
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (!r_active[r_idx])     r_state <= S_NEXT;
          else if (r_fresh[r_idx])  r_state <= S_DRAW;
          else                      r_state <= S_ERASE;
        end
        S_ERASE: begin
          r_x     <= r_px[r_idx];
          r_y     <= r_py[r_idx];
          r_color <= 3'b000;
          r_wren  <= 1'b1;
          r_state <= S_MOVE;
        end
        S_MOVE: begin
          r_px[r_idx] <= w_nx;
          r_py[r_idx] <= w_ny;
          if (w_oob) begin
            r_active[r_idx] <= 1'b0;
            r_state         <= S_NEXT;
          end else begin
            r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          r_x            <= r_px[r_idx];
          r_y            <= r_py[r_idx];
          r_color        <= BULLET_COLOR;
          r_wren         <= 1'b1;
          r_fresh[r_idx] <= 1'b0;
          r_state        <= S_NEXT;
        end
        S_NEXT: begin
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= S_SCAN;
          end
        end
        S_DONE: begin
          if (start) begin
            r_done <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_active_count <= '0;
    else         r_active_count <= w_pop;
  end

  assign x            = r_x;
  assign y            = r_y;
  assign color        = r_color;
  assign wren         = r_wren;
  assign done         = r_done;
  assign active_count = r_active_count;

endmodule

// File: tb/tb_boss_bullet_pool.sv
// Bench for boss_bullet_pool: directed frame table, hand-built corner sequences and
// random frames, all compared against a slot-list model of the bullet rules.
module tb_boss_bullet_pool;

  localparam int NB       = 8;
  localparam int FP       = 4;
  localparam int SW       = 160;
  localparam int SH       = 120;
  localparam int XO       = 4;
  localparam int YS       = 90;
  localparam int COL      = 5;
  localparam int BUDGET   = 1000;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] boss_x;
  logic [6:0] boss_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       wren;
  logic       done;
  logic [3:0] active_count;

  boss_bullet_pool dut (
    .clk(clk), .resetn(resetn), .start(start), .boss_x(boss_x), .boss_y(boss_y),
    .x(x), .y(y), .color(color), .wren(wren), .done(done), .active_count(active_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] wr(input int wx, input int wy, input int wc);
    return {8'(wx), 7'(wy), 3'(wc)};
  endfunction

  // Reference model: a plain list of slots, advanced one whole frame at a time.
  bit m_act[NB];
  bit m_fresh[NB];
  int m_px[NB], m_py[NB], m_dx[NB], m_dy[NB];
  int m_fc, m_pat;
  int pat_dx[3] = '{0, -1, 1};
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int exp_lat, exp_active, last_lat;

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_act[i] = 0; m_fresh[i] = 0; m_px[i] = 0; m_py[i] = 0; m_dx[i] = 0; m_dy[i] = 0;
    end
    m_fc = 0; m_pat = 0;
  endtask

  task automatic model_frame(input int bx, input int by);
    int slot;
    exp_q.delete();
    exp_lat = 2;
    if (m_fc == FP - 1) begin
      m_fc = 0;
      slot = -1;
      for (int i = NB - 1; i >= 0; i--) if (!m_act[i]) slot = i;
      if (slot >= 0) begin
        m_act[slot] = 1; m_fresh[slot] = 1;
        m_px[slot] = (bx + XO) % 256; m_py[slot] = by;
        m_dy[slot] = (by > YS) ? -1 : 1;
        m_dx[slot] = pat_dx[m_pat];
        m_pat = (m_pat + 1) % 3;
      end
    end else begin
      m_fc++;
    end
    for (int i = 0; i < NB; i++) begin
      if (!m_act[i]) begin
        exp_lat += 2;
      end else if (m_fresh[i]) begin
        exp_q.push_back(wr(m_px[i], m_py[i], COL));
        m_fresh[i] = 0;
        exp_lat += 3;
      end else begin
        exp_q.push_back(wr(m_px[i], m_py[i], 0));
        m_px[i] = (m_px[i] + m_dx[i] + 256) % 256;
        m_py[i] = (m_py[i] + m_dy[i] + 128) % 128;
        if (m_px[i] >= SW || m_py[i] >= SH) begin
          m_act[i] = 0;
          exp_lat += 4;
        end else begin
          exp_q.push_back(wr(m_px[i], m_py[i], COL));
          exp_lat += 5;
        end
      end
    end
    exp_active = 0;
    for (int i = 0; i < NB; i++) exp_active += int'(m_act[i]);
  endtask

  task automatic do_reset();
    resetn = 1'b0; start = 1'b0; boss_x = '0; boss_y = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] bx, input logic [6:0] by);
    int cycles;
    bit seen;
    model_frame(int'(bx), int'(by));
    boss_x = bx; boss_y = by; start = 1'b1;
    got_q.delete();
    cycles = 0; seen = 0;
    while (!seen && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
      if (wren) got_q.push_back({x, y, color});
      if (done) seen = 1;
    end
    last_lat = cycles - 1;
    check("done_seen", 32'(seen), 1);
    check("frame_latency", last_lat, exp_lat);
    check("write_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("write_xyc", 32'(got_q[i]), 32'(exp_q[i]));
    check("active_count", 32'(active_count), exp_active);
    start = 1'b0;
    @(negedge clk);
    check("done_clear", 32'(done), 0);
  endtask

  function automatic int count_writes(input logic [17:0] w);
    int n = 0;
    foreach (got_q[i]) if (got_q[i] == w) n++;
    return n;
  endfunction

  typedef struct {
    logic [7:0]  bx;
    logic [6:0]  by;
    int          lat;
    int          nw;
    int          act;
    logic [17:0] last_w;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int n;
    int tx, ty;
    bit hit;
    logic [17:0] tw;

    vecs[0]  = '{8'd50, 7'd20, 18, 0, 0, 18'd0};
    vecs[1]  = '{8'd50, 7'd20, 18, 0, 0, 18'd0};
    vecs[2]  = '{8'd50, 7'd20, 18, 0, 0, 18'd0};
    vecs[3]  = '{8'd50, 7'd20, 19, 1, 1, {8'd54, 7'd20, 3'd5}};
    vecs[4]  = '{8'd50, 7'd20, 21, 2, 1, {8'd54, 7'd21, 3'd5}};
    vecs[5]  = '{8'd50, 7'd20, 21, 2, 1, {8'd54, 7'd22, 3'd5}};
    vecs[6]  = '{8'd50, 7'd20, 21, 2, 1, {8'd54, 7'd23, 3'd5}};
    vecs[7]  = '{8'd50, 7'd20, 22, 3, 2, {8'd54, 7'd20, 3'd5}};
    vecs[8]  = '{8'd50, 7'd20, 24, 4, 2, {8'd53, 7'd21, 3'd5}};
    vecs[9]  = '{8'd50, 7'd20, 24, 4, 2, {8'd52, 7'd22, 3'd5}};
    vecs[10] = '{8'd50, 7'd20, 24, 4, 2, {8'd51, 7'd23, 3'd5}};
    vecs[11] = '{8'd50, 7'd20, 25, 5, 3, {8'd54, 7'd20, 3'd5}};
    vecs[12] = '{8'd50, 7'd20, 27, 6, 3, {8'd55, 7'd21, 3'd5}};
    vecs[13] = '{8'd50, 7'd20, 27, 6, 3, {8'd56, 7'd22, 3'd5}};

    do_reset();
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_color", 32'(color), 0);
    check("rst_wren", 32'(wren), 0);
    check("rst_done", 32'(done), 0);
    check("rst_active", 32'(active_count), 0);

    // Directed frames from reset with a stationary boss.
    for (int v = 0; v < 14; v++) begin
      run_frame(vecs[v].bx, vecs[v].by);
      check("tbl_latency", last_lat, vecs[v].lat);
      check("tbl_writes", got_q.size(), vecs[v].nw);
      check("tbl_active", 32'(active_count), vecs[v].act);
      if (vecs[v].nw > 0) check("tbl_last_write", 32'(got_q[got_q.size()-1]), 32'(vecs[v].last_w));
    end

    // Right-edge exit: third spawn at px=159 moving +1 is erased, never redrawn.
    do_reset();
    for (int f = 1; f <= 12; f++) run_frame(8'd155, 7'd20);
    run_frame(8'd155, 7'd20);
    check("edge_erase", count_writes(wr(159, 20, 0)), 1);
    n = 0;
    foreach (got_q[i]) if (got_q[i][17:10] == 8'd160) n++;
    check("edge_no_draw", n, 0);
    check("edge_latency", last_lat, 26);
    check("edge_active", 32'(active_count), 2);

    // Upward bullet wraps from py=0 to 127 and is freed without a draw.
    do_reset();
    for (int f = 1; f <= 95; f++) run_frame(8'd50, 7'd91);
    run_frame(8'd50, 7'd91);
    check("up_erase_top", count_writes(wr(54, 0, 0)), 1);
    n = 0;
    foreach (got_q[i]) if (got_q[i][9:3] == 7'd127) n++;
    check("up_no_draw", n, 0);
    check("up_active", 32'(active_count), 7);

    // Full pool: spawns are dropped and the fire pattern holds its place.
    do_reset();
    for (int f = 1; f <= 35; f++) run_frame(8'd76, 7'd0);
    run_frame(8'd76, 7'd0);
    check("full_active", 32'(active_count), 8);
    check("full_writes", got_q.size(), 16);
    check("full_latency", last_lat, 42);
    check("full_no_spawn", count_writes(wr(80, 0, COL)), 0);
    for (int f = 37; f <= 91; f++) run_frame(8'd76, 7'd0);
    run_frame(8'd76, 7'd0);
    check("refill_spawn", count_writes(wr(80, 0, COL)), 1);
    run_frame(8'd76, 7'd0);
    check("refill_dx_plus", count_writes(wr(81, 1, COL)), 1);

    // Reset while slot 3 is being erased: outputs clear at once, next frame is empty.
    tx = m_px[3]; ty = m_py[3];
    tw = wr(tx, ty, 0);
    boss_x = 8'd76; boss_y = 7'd0; start = 1'b1;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (wren && {x, y, color} == tw) hit = 1;
    end
    check("rst_target_seen", 32'(hit), 1);
    resetn = 1'b0;
    #1;
    check("async_x", 32'(x), 0);
    check("async_y", 32'(y), 0);
    check("async_color", 32'(color), 0);
    check("async_wren", 32'(wren), 0);
    check("async_done", 32'(done), 0);
    check("async_active", 32'(active_count), 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    run_frame(8'd50, 7'd20);
    check("post_rst_latency", last_lat, 18);
    check("post_rst_writes", got_q.size(), 0);
    check("post_rst_active", 32'(active_count), 0);

    // Random boss positions and idle gaps against the model.
    do_reset();
    for (int f = 0; f < 60; f++) begin
      run_frame(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
